inst_sram_axi_bridge: RTL and testbench
=======================================

INST_SRAM_AXI_BRIDGE -- requirements
Module: inst_sram_axi_bridge

Interface
REQ-001 SHALL have parameter ARID, default 4'd0: fixed AXI read ID driven on arid and matched on rid.
REQ-002 SHALL have parameter MAX_OUT, default 2: maximum accepted-but-not-returned requests (legal range 1..3).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port inst_sram_req  input  1  SRAM-like request valid from fetch stage.
REQ-006 SHALL have port inst_sram_wr  input  1  write flag; ignored, every request treated as read.
REQ-007 SHALL have port inst_sram_size  input  2  transfer size, log2 bytes.
REQ-008 SHALL have port inst_sram_addr  input  32  request byte address.
REQ-009 SHALL have port inst_sram_addr_ok  output  1  request accepted this cycle.
REQ-010 SHALL have port inst_sram_data_ok  output  1  one read datum returned this cycle.
REQ-011 SHALL have port inst_sram_rdata  output  32  returned instruction word.
REQ-012 SHALL have port arid  output  4  AXI AR ID, constant ARID.
REQ-013 SHALL have port araddr  output  32  AXI AR address.
REQ-014 SHALL have port arlen  output  8  AXI burst length, constant 0.
REQ-015 SHALL have port arsize  output  3  AXI size, {1'b0, latched inst_sram_size}.
REQ-016 SHALL have port arburst  output  2  AXI burst type, constant 2'b01.
REQ-017 SHALL have port arvalid  output  1  AXI AR valid.
REQ-018 SHALL have port arready  input  1  AXI AR ready.
REQ-019 SHALL have port rid  input  4  AXI R ID.
REQ-020 SHALL have port rdata  input  32  AXI R data.
REQ-021 SHALL have port rresp  input  2  AXI R response; ignored, no error reporting.
REQ-022 SHALL have port rlast  input  1  AXI R last; ignored (single-beat only).
REQ-023 SHALL have port rvalid  input  1  AXI R valid.
REQ-024 SHALL have port rready  output  1  AXI R ready.

Function
REQ-025 AR FSM SHALL have two states: AR_IDLE (arvalid=0) and AR_REQ (arvalid=1).
REQ-026 inst_sram_addr_ok SHALL be combinational: 1 iff state==AR_IDLE & inst_sram_req & cnt<MAX_OUT.
REQ-027 On addr_ok, araddr/arsize SHALL latch addr/size and FSM SHALL enter AR_REQ next cycle.
REQ-028 In AR_REQ, arvalid and araddr SHALL hold stable until arvalid&arready, then FSM returns to AR_IDLE next cycle; minimum two cycles per request.
REQ-029 Outstanding counter cnt (2 bits) SHALL +1 on addr_ok, -1 on accepted matching R beat, unchanged when both occur same cycle; never wraps.
REQ-030 rready SHALL be 1 iff cnt!=0; no backpressure otherwise.
REQ-031 A beat with rvalid&rready&rid==ARID SHALL register: inst_sram_data_ok=1 and inst_sram_rdata=rdata on the next cycle, one-cycle pulse, rdata held until next return.
REQ-032 A beat with rid!=ARID SHALL be accepted (rready=1) and dropped: no data_ok, cnt unchanged.
REQ-033 Returns SHALL be in request order (AXI same-ID ordering); no reordering buffer.
REQ-034 Request accepted when cnt==MAX_OUT-1 and a return in the same cycle SHALL both take effect.

Reset
REQ-035 On resetn==0 at a clock edge: state=AR_IDLE, cnt=0, arvalid=0, araddr=0, arsize=0, data_ok=0, inst_sram_rdata=0; any in-flight AR or R beat abandoned.
REQ-036 While resetn==0, addr_ok SHALL be 0 and rready SHALL be 0.

Verification
REQ-037 Single read: req addr=0x1C000000 size=2, arready=1 -> addr_ok cycle 0, arvalid cycle 1 araddr=0x1C000000 arsize=2; R rdata=0x02800000 cycle 3 -> data_ok cycle 4 rdata=0x02800000.
REQ-038 Back-pressure: arready=0 for 3 cycles -> arvalid held 4 cycles, araddr stable, addr_ok=0 throughout.
REQ-039 Outstanding limit MAX_OUT=2, no R: two requests accepted, third req held -> addr_ok=0 until first R beat, then accepted.
REQ-040 Simultaneous accept+return at cnt=1 -> cnt stays 1, data_ok next cycle, new AR issued.
REQ-041 rid=4'd1 beat -> rready=1, no data_ok, cnt unchanged; following rid=0 beat returns data.
REQ-042 resetn low while arvalid=1, cnt=1 -> next cycle arvalid=0, cnt=0, rready=0, data_ok=0.

Source files
------------

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-fetch bridge: turns SRAM-like fetch requests into single-beat AXI reads.
// All requests share one AXI ID, so read data comes back in request order.
module inst_sram_axi_bridge #(
    parameter logic [3:0] ARID    = 4'd0,
    parameter int         MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        dbg_ar_state,
    output logic [1:0]  dbg_cnt
);

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_REQ  = 1'b1
    } ar_state_t;

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

    ar_state_t  ar_state;
    logic [1:0] cnt;
    logic       r_take;
    logic       unused_ok;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // arvalid/araddr/arsize never change while arvalid is high and arready is low.
    assign inst_sram_addr_ok = resetn && (ar_state == AR_IDLE) && inst_sram_req && (cnt < MAX_CNT);
    assign rready            = resetn && (cnt != 2'd0);
    assign r_take            = rvalid && rready && (rid == ARID);

    assign arid    = ARID;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;

    assign dbg_ar_state = ar_state;
    assign dbg_cnt      = cnt;

    assign unused_ok = ^{inst_sram_wr, rresp, rlast};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state          <= AR_IDLE;
            arvalid           <= 1'b0;
            araddr            <= 32'd0;
            arsize            <= 3'd0;
            cnt               <= 2'd0;
            inst_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= 32'd0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (inst_sram_addr_ok) begin
                        ar_state <= AR_REQ;
                        arvalid  <= 1'b1;
                        araddr   <= inst_sram_addr;
                        arsize   <= {1'b0, inst_sram_size};
                    end
                end
                AR_REQ: begin
                    if (arready) begin
                        ar_state <= AR_IDLE;
                        arvalid  <= 1'b0;
                    end
                end
                default: begin
                    ar_state <= AR_IDLE;
                    arvalid  <= 1'b0;
                end
            endcase

            // An accept and a return in the same cycle cancel out.
            case ({inst_sram_addr_ok, r_take})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase

            inst_sram_data_ok <= r_take;
            if (r_take) begin
                inst_sram_rdata <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge: single read, AR back-pressure, outstanding
// limit, simultaneous accept/return, foreign-ID beats and reset abandonment.
module tb_inst_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        dbg_ar_state;
    logic [1:0]  dbg_cnt;

    int n_vec;
    int n_err;

    inst_sram_axi_bridge #(.ARID(4'd0), .MAX_OUT(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready),
        .dbg_ar_state      (dbg_ar_state),
        .dbg_cnt           (dbg_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic req, input logic [31:0] addr, input logic [1:0] size);
        inst_sram_req  = req;
        inst_sram_addr = addr;
        inst_sram_size = size;
    endtask

    task automatic drive_r(input logic valid, input logic [3:0] id, input logic [31:0] data);
        rvalid = valid;
        rid    = id;
        rdata  = data;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        inst_sram_wr = 1'b0;
        drive_req(1'b1, 32'h0000_0040, 2'd2);
        arready = 1'b1;
        rresp = 2'b00;
        rlast = 1'b1;
        drive_r(1'b0, 4'd0, 32'd0);

        // reset state
        next_cycle();
        next_cycle();
        mid();
        check("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
        check("rst_rdata", inst_sram_rdata, 32'd0);
        check("rst_cnt", 32'(dbg_cnt), 32'd0);
        check("const_arid", 32'(arid), 32'd0);
        check("const_arlen", 32'(arlen), 32'd0);
        check("const_arburst", 32'(arburst), 32'd1);
        next_cycle();
        drive_req(1'b0, 32'd0, 2'd0);
        resetn = 1'b1;
        next_cycle();

        // single read
        drive_req(1'b1, 32'h1C00_0000, 2'd2);
        mid();
        check("single_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        next_cycle();
        drive_req(1'b0, 32'd0, 2'd0);
        mid();
        check("single_arvalid", 32'(arvalid), 32'd1);
        check("single_araddr", araddr, 32'h1C00_0000);
        check("single_arsize", 32'(arsize), 32'd2);
        check("single_state", 32'(dbg_ar_state), 32'd1);
        next_cycle();
        mid();
        check("single_ar_done", 32'(arvalid), 32'd0);
        check("single_rready", 32'(rready), 32'd1);
        check("single_cnt", 32'(dbg_cnt), 32'd1);
        next_cycle();
        drive_r(1'b1, 4'd0, 32'h0280_0000);
        mid();
        check("single_no_early_ok", 32'(inst_sram_data_ok), 32'd0);
        next_cycle();
        drive_r(1'b0, 4'd0, 32'd0);
        mid();
        check("single_data_ok", 32'(inst_sram_data_ok), 32'd1);
        check("single_rdata", inst_sram_rdata, 32'h0280_0000);
        check("single_cnt_back", 32'(dbg_cnt), 32'd0);
        next_cycle();
        mid();
        check("single_ok_pulse", 32'(inst_sram_data_ok), 32'd0);
        check("single_rdata_hold", inst_sram_rdata, 32'h0280_0000);
        next_cycle();

        // AR back-pressure: request stays asserted throughout
        arready = 1'b0;
        drive_req(1'b1, 32'h1C00_0004, 2'd1);
        mid();
        check("bp_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_req(1'b1, 32'h1C00_0100 + 32'(i), 2'd2);
            if (i == 3) arready = 1'b1;
            mid();
            check($sformatf("bp_arvalid_%0d", i), 32'(arvalid), 32'd1);
            check($sformatf("bp_araddr_%0d", i), araddr, 32'h1C00_0004);
            check($sformatf("bp_arsize_%0d", i), 32'(arsize), 32'd1);
            check($sformatf("bp_no_addr_ok_%0d", i), 32'(inst_sram_addr_ok), 32'd0);
        end
        next_cycle();
        drive_req(1'b0, 32'd0, 2'd0);
        mid();
        check("bp_ar_done", 32'(arvalid), 32'd0);
        drive_r(1'b1, 4'd0, 32'hAAAA_0001);
        next_cycle();
        drive_r(1'b0, 4'd0, 32'd0);
        mid();
        check("bp_rdata", inst_sram_rdata, 32'hAAAA_0001);
        check("bp_cnt", 32'(dbg_cnt), 32'd0);
        next_cycle();

        // outstanding limit, then simultaneous accept + return at cnt=1
        drive_req(1'b1, 32'h0000_0100, 2'd2);
        mid();
        check("lim_a_ok", 32'(inst_sram_addr_ok), 32'd1);
        next_cycle();
        drive_req(1'b0, 32'd0, 2'd0);
        next_cycle();
        drive_req(1'b1, 32'h0000_0104, 2'd2);
        mid();
        check("lim_b_ok", 32'(inst_sram_addr_ok), 32'd1);
        next_cycle();
        drive_req(1'b1, 32'h0000_0108, 2'd2);
        mid();
        check("lim_b_araddr", araddr, 32'h0000_0104);
        next_cycle();
        mid();
        check("lim_c_blocked0", 32'(inst_sram_addr_ok), 32'd0);
        check("lim_cnt2", 32'(dbg_cnt), 32'd2);
        next_cycle();
        mid();
        check("lim_c_blocked1", 32'(inst_sram_addr_ok), 32'd0);
        next_cycle();
        drive_r(1'b1, 4'd0, 32'hD000_0001);
        mid();
        check("lim_c_blocked2", 32'(inst_sram_addr_ok), 32'd0);
        next_cycle();
        drive_r(1'b0, 4'd0, 32'd0);
        mid();
        check("lim_c_ok", 32'(inst_sram_addr_ok), 32'd1);
        check("lim_d1_ok", 32'(inst_sram_data_ok), 32'd1);
        check("lim_d1", inst_sram_rdata, 32'hD000_0001);
        next_cycle();
        drive_req(1'b0, 32'd0, 2'd0);
        mid();
        check("lim_c_araddr", araddr, 32'h0000_0108);
        next_cycle();
        drive_r(1'b1, 4'd0, 32'hD000_0002);
        next_cycle();
        drive_r(1'b1, 4'd0, 32'hD000_0003);
        drive_req(1'b1, 32'h0000_010C, 2'd2);
        mid();
        check("sim_cnt1", 32'(dbg_cnt), 32'd1);
        check("sim_d2", inst_sram_rdata, 32'hD000_0002);
        check("sim_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        next_cycle();
        drive_r(1'b0, 4'd0, 32'd0);
        drive_req(1'b0, 32'd0, 2'd0);
        mid();
        check("sim_cnt_stays", 32'(dbg_cnt), 32'd1);
        check("sim_data_ok", 32'(inst_sram_data_ok), 32'd1);
        check("sim_d3", inst_sram_rdata, 32'hD000_0003);
        check("sim_arvalid", 32'(arvalid), 32'd1);
        check("sim_araddr", araddr, 32'h0000_010C);
        next_cycle();
        drive_r(1'b1, 4'd0, 32'hD000_0004);
        next_cycle();
        drive_r(1'b0, 4'd0, 32'd0);
        mid();
        check("sim_d4", inst_sram_rdata, 32'hD000_0004);
        check("sim_cnt0", 32'(dbg_cnt), 32'd0);
        next_cycle();

        // foreign-ID beat is swallowed
        drive_req(1'b1, 32'h0000_0200, 2'd2);
        next_cycle();
        drive_req(1'b0, 32'd0, 2'd0);
        next_cycle();
        drive_r(1'b1, 4'd1, 32'hBAD0_BAD0);
        mid();
        check("rid_rready", 32'(rready), 32'd1);
        next_cycle();
        drive_r(1'b1, 4'd0, 32'h600D_600D);
        mid();
        check("rid_no_data_ok", 32'(inst_sram_data_ok), 32'd0);
        check("rid_cnt_kept", 32'(dbg_cnt), 32'd1);
        check("rid_rdata_kept", inst_sram_rdata, 32'hD000_0004);
        next_cycle();
        drive_r(1'b0, 4'd0, 32'd0);
        mid();
        check("rid_good_ok", 32'(inst_sram_data_ok), 32'd1);
        check("rid_good_data", inst_sram_rdata, 32'h600D_600D);
        next_cycle();

        // reset while a request is in flight
        arready = 1'b0;
        drive_req(1'b1, 32'h0000_0300, 2'd2);
        next_cycle();
        drive_req(1'b1, 32'h0000_0304, 2'd2);
        mid();
        check("rst2_arvalid_pre", 32'(arvalid), 32'd1);
        check("rst2_cnt_pre", 32'(dbg_cnt), 32'd1);
        next_cycle();
        resetn = 1'b0;
        drive_r(1'b1, 4'd0, 32'hFEED_0001);
        mid();
        check("rst2_rready_low", 32'(rready), 32'd0);
        check("rst2_addr_ok_low", 32'(inst_sram_addr_ok), 32'd0);
        next_cycle();
        mid();
        check("rst2_arvalid", 32'(arvalid), 32'd0);
        check("rst2_cnt", 32'(dbg_cnt), 32'd0);
        check("rst2_data_ok", 32'(inst_sram_data_ok), 32'd0);
        check("rst2_araddr", araddr, 32'd0);
        check("rst2_rready", 32'(rready), 32'd0);
        next_cycle();
        resetn = 1'b1;
        drive_r(1'b0, 4'd0, 32'd0);
        drive_req(1'b0, 32'd0, 2'd0);
        arready = 1'b1;
        next_cycle();
        mid();
        check("rst2_idle_state", 32'(dbg_ar_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
